// File: rtl/tc_program_port_arbiter_if.sv
// ============================================================================
// Module   : tc_program_port_arbiter_if
// Brief    : Request/response and program-memory signal bundle for the
//            program-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tc_program_port_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_address;
    logic [7:0]        mem_out0;
    logic [7:0]        mem_out1;
    logic [7:0]        mem_out2;
    logic [7:0]        mem_out3;

    logic              req0_valid;
    logic              req1_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [ADDR_W-1:0] req1_addr;
    logic              req0_ready;
    logic              req1_ready;

    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [31:0]       rsp0_data;
    logic [31:0]       rsp1_data;
    logic              rsp0_ready;
    logic              rsp1_ready;

    logic              busy;

    // Arbiter side
    modport slave (
        output mem_address,
        input  mem_out0, mem_out1, mem_out2, mem_out3,
        input  req0_valid, req1_valid, req0_addr, req1_addr,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
        input  rsp0_ready, rsp1_ready,
        output busy
    );

    // Requester / memory side
    modport master (
        input  mem_address,
        output mem_out0, mem_out1, mem_out2, mem_out3,
        output req0_valid, req1_valid, req0_addr, req1_addr,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
        output rsp0_ready, rsp1_ready,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/tc_program_port_arbiter.sv
// ============================================================================
// Module   : tc_program_port_arbiter
// Brief    : Shares the 4-byte program-memory read port between instruction
//            fetch (req0) and data load (req1); one read in flight, buffered
//            per-requester responses. Optional TC_PROG_ARB_FIXED_PRIO_EN makes
//            fetch win every tie instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_program_port_arbiter #(
    parameter int ADDR_W = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    tc_program_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_mem_address;
    logic              r_owner;
    logic              r_last_grant;
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;
    logic [31:0]       r_rsp0_data;
    logic [31:0]       r_rsp1_data;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_grant0;
    logic              w_grant1;
    logic [31:0]       w_mem_word;

    assign w_mem_word = {bus.mem_out3, bus.mem_out2, bus.mem_out1, bus.mem_out0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A full response buffer blocks its requester, even if it drains this cycle.
    always_comb begin
        w_state_next = r_state;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        w_elig0      = bus.req0_valid && !r_rsp0_valid;
        w_elig1      = bus.req1_valid && !r_rsp1_valid;
        case (r_state)
            S_IDLE: begin
                if (!rst) begin
                    if (w_elig0 && w_elig1) begin
`ifdef TC_PROG_ARB_FIXED_PRIO_EN
                        w_grant0 = 1'b1;
`else
                        w_grant0 = r_last_grant;
                        w_grant1 = !r_last_grant;
`endif
                    end else begin
                        w_grant0 = w_elig0;
                        w_grant1 = w_elig1;
                    end
                    if (w_elig0 || w_elig1) begin
                        w_state_next = S_ADDR;
                    end
                end
            end
            S_ADDR:  w_state_next = S_DATA;
            S_DATA:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_address <= '0;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_rsp0_valid  <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp0_data   <= '0;
            r_rsp1_data   <= '0;
        end else begin
            if (w_grant0 || w_grant1) begin
                r_mem_address <= w_grant1 ? bus.req1_addr : bus.req0_addr;
                r_owner       <= w_grant1;
                r_last_grant  <= w_grant1;
            end

            if (bus.rsp0_ready) begin
                r_rsp0_valid <= 1'b0;
            end
            if (bus.rsp1_ready) begin
                r_rsp1_valid <= 1'b0;
            end

            // Memory output is valid in DATA; the owner's buffer is empty here.
            if (r_state == S_DATA) begin
                if (r_owner) begin
                    r_rsp1_valid <= 1'b1;
                    r_rsp1_data  <= w_mem_word;
                end else begin
                    r_rsp0_valid <= 1'b1;
                    r_rsp0_data  <= w_mem_word;
                end
            end
        end
    end

    assign bus.mem_address = r_mem_address;
    assign bus.req0_ready  = w_grant0;
    assign bus.req1_ready  = w_grant1;
    assign bus.rsp0_valid  = r_rsp0_valid;
    assign bus.rsp1_valid  = r_rsp1_valid;
    assign bus.rsp0_data   = r_rsp0_data;
    assign bus.rsp1_data   = r_rsp1_data;
    assign bus.busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_tc_program_port_arbiter.sv
// ============================================================================
// Module   : tb_tc_program_port_arbiter
// Brief    : Bench for tc_program_port_arbiter: directed scenarios with literal
//            expectations plus randomized traffic against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tc_program_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tc_program_port_arbiter_if #(.ADDR_W(16)) bus ();

    tc_program_port_arbiter #(.ADDR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic        req_valid [2];
    logic [15:0] req_addr  [2];
    logic        rsp_ready [2];

    assign bus.req0_valid = req_valid[0];
    assign bus.req1_valid = req_valid[1];
    assign bus.req0_addr  = req_addr[0];
    assign bus.req1_addr  = req_addr[1];
    assign bus.rsp0_ready = rsp_ready[0];
    assign bus.rsp1_ready = rsp_ready[1];

    // Program memory: registered read of four consecutive bytes, 16-bit wrap.
    logic [7:0] mem [65536];

    function automatic logic [31:0] mword(input logic [15:0] a);
        return {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
    endfunction

    always @(posedge clk) begin
        bus.mem_out0 <= mem[bus.mem_address];
        bus.mem_out1 <= mem[bus.mem_address + 16'd1];
        bus.mem_out2 <= mem[bus.mem_address + 16'd2];
        bus.mem_out3 <= mem[bus.mem_address + 16'd3];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: m_cnt counts cycles left before the read lands.
    int          m_cnt = 0;
    logic        m_owner = 1'b0;
    logic        m_last = 1'b1;
    logic [15:0] m_addr = '0;
    logic        m_rv [2];
    logic [31:0] m_rd [2];
    bit          acc  [2];
    int          acc0_q [$];

    function automatic int m_winner();
        logic e0, e1;
        e0 = req_valid[0] && !m_rv[0];
        e1 = req_valid[1] && !m_rv[1];
        if (rst || m_cnt != 0) return -1;
        if (e0 && e1) begin
`ifdef TC_PROG_ARB_FIXED_PRIO_EN
            return 0;
`else
            return m_last ? 0 : 1;
`endif
        end
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        w = m_winner();
        acc[0] = (w == 0);
        acc[1] = (w == 1);
        if (w == 0) acc0_q.push_back(cyc);
        if (rst) begin
            m_cnt = 0; m_owner = 1'b0; m_last = 1'b1; m_addr = '0;
            for (int i = 0; i < 2; i++) begin
                m_rv[i] = 1'b0;
                m_rd[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_rv[i] && rsp_ready[i]) m_rv[i] = 1'b0;
            end
            if (m_cnt == 1) begin
                m_rv[m_owner] = 1'b1;
                m_rd[m_owner] = mword(m_addr);
                m_cnt = 0;
            end else if (m_cnt == 2) begin
                m_cnt = 1;
            end else if (w >= 0) begin
                m_addr  = req_addr[w];
                m_owner = (w == 1);
                m_last  = (w == 1);
                m_cnt   = 2;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        int w;
        if (chk_en) begin
            w = m_winner();
            chk("req0_ready", 32'(bus.req0_ready), 32'(w == 0));
            chk("req1_ready", 32'(bus.req1_ready), 32'(w == 1));
            chk("busy",       32'(bus.busy),       32'(m_cnt != 0));
            chk("mem_address", 32'(bus.mem_address), 32'(m_addr));
            chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(m_rv[0]));
            chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(m_rv[1]));
            chk("rsp0_data",  bus.rsp0_data, m_rd[0]);
            chk("rsp1_data",  bus.rsp1_data, m_rd[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22;
        mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
        mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB;
        mem[16'h0000] = 8'hCC; mem[16'h0001] = 8'hDD;

        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_addr[i] = '0; rsp_ready[i] = 1'b0;
        end
        req_valid[0] = 1'b1;
        req_addr[0]  = 16'h0010;
        rst = 1'b1;
        step(); step();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
        chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        chk("rst_rsp1_data", bus.rsp1_data, 32'd0);
        chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);

        // Single fetch
        step(); rst = 1'b0;
        @(negedge clk); chk("fetch_ready", 32'(bus.req0_ready), 32'd1);
        step(); req_valid[0] = 1'b0;
        @(negedge clk);
        chk("fetch_addr", 32'(bus.mem_address), 32'h0010);
        chk("fetch_busy1", 32'(bus.busy), 32'd1);
        step();
        @(negedge clk); chk("fetch_busy2", 32'(bus.busy), 32'd1);
        step(); rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("fetch_rsp_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("fetch_rsp_data", bus.rsp0_data, 32'h44332211);
        chk("fetch_idle", 32'(bus.busy), 32'd0);

        // Wrap address on the load port
        step(); rsp_ready[0] = 1'b0; req_valid[1] = 1'b1; req_addr[1] = 16'hFFFE;
        @(negedge clk); chk("wrap_ready", 32'(bus.req1_ready), 32'd1);
        step(); req_valid[1] = 1'b0;
        @(negedge clk); chk("wrap_addr", 32'(bus.mem_address), 32'hFFFE);
        step();
        step(); rsp_ready[1] = 1'b1;
        @(negedge clk); chk("wrap_data", bus.rsp1_data, 32'hDDCCBBAA);
        step(); rsp_ready[1] = 1'b0;

        // Tie after reset goes to fetch, then the held load
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        req_valid[0] = 1'b1; req_addr[0] = 16'h0100;
        req_valid[1] = 1'b1; req_addr[1] = 16'h0200;
        @(negedge clk);
        chk("tie_req0", 32'(bus.req0_ready), 32'd1);
        chk("tie_req1", 32'(bus.req1_ready), 32'd0);
        step(); req_valid[0] = 1'b0;
        step();
        step();
        @(negedge clk); chk("tie_req1_next", 32'(bus.req1_ready), 32'd1);
        step(); req_valid[1] = 1'b0; rsp_ready[0] = 1'b1;
        step(); rsp_ready[0] = 1'b0;
        step();

        // Backpressure: rsp1 full, fetch still served, load waits for drain
        step();
        req_valid[0] = 1'b1; req_addr[0] = 16'h0400;
        req_valid[1] = 1'b1; req_addr[1] = 16'h0300;
        @(negedge clk);
        chk("bp_req1_blocked", 32'(bus.req1_ready), 32'd0);
        chk("bp_req0_served", 32'(bus.req0_ready), 32'd1);
        step(); req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
        step();
        step();
        @(negedge clk); chk("bp_req1_idle_blocked", 32'(bus.req1_ready), 32'd0);
        step(); rsp_ready[1] = 1'b1;
        @(negedge clk); chk("bp_drain_cycle", 32'(bus.req1_ready), 32'd0);
        step(); rsp_ready[1] = 1'b0;
        @(negedge clk); chk("bp_after_drain", 32'(bus.req1_ready), 32'd1);
        step(); req_valid[1] = 1'b0;

        // Reset while the load read is in DATA
        step(); rst = 1'b1;
        @(negedge clk); chk("rstdata_busy", 32'(bus.busy), 32'd1);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("rstdata_idle", 32'(bus.busy), 32'd0);
        chk("rstdata_rsp1", 32'(bus.rsp1_valid), 32'd0);
        chk("rstdata_addr", 32'(bus.mem_address), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk); chk("rstdata_no_rsp", 32'(bus.rsp1_valid), 32'd0);
        end

        // Streaming fetch with an always-ready consumer
        step();
        acc0_q.delete();
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1; req_addr[0] = 16'h1000;
        n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            step();
            if (acc[0]) begin
                n++;
                req_addr[0] = req_addr[0] + 16'h0104;
            end
        end
        chk("stream_accepts", 32'(acc0_q.size()), 32'd3);
        if (acc0_q.size() >= 3) begin
            chk("stream_gap1", 32'(acc0_q[1] - acc0_q[0]), 32'd4);
            chk("stream_gap2", 32'(acc0_q[2] - acc0_q[1]), 32'd4);
        end
        req_valid[0] = 1'b0;
        step();

        // Randomized traffic; addresses held until accepted
        for (int c = 0; c < 4000; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom % 3) != 0;
                    req_addr[i]  = 16'($urandom);
                end
                rsp_ready[i] = ($urandom % 4) != 0;
            end
            rst = ($urandom % 250) == 0;
        end
        step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
